// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode constants, ALUOp and mux select codes, and the raw control word
// produced by the per-state decoder.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_RTYPE    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; enables here are not yet qualified by
  // MemReady, Zero or reset.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       reg_write;
    logic       regdst;
    logic       memtoreg;
  } ctrl_word_t;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_word_decode.sv
// Pure combinational decode of the controller state into its control word.
// Ports:
//   state_i  current FSM state
//   cw_o     raw control word (enables not gated by MemReady/Zero/reset)
module ctrl_word_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.mem_req  = 1'b1;
        cw_o.iord     = 1'b0;
        cw_o.ir_write = 1'b1;
        cw_o.pc_write = 1'b1;
        cw_o.alusrca  = 1'b0;
        cw_o.alusrcb  = SRCB_FOUR;
        cw_o.aluop    = ALUOP_ADD;
        cw_o.pcsrc    = PCSRC_ALURES;
      end
      S_DECODE: begin
        cw_o.alusrca = 1'b0;
        cw_o.alusrcb = SRCB_IMMSH2;
        cw_o.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_IMM;
        cw_o.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        cw_o.mem_req = 1'b1;
        cw_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.regdst    = 1'b0;
        cw_o.memtoreg  = 1'b1;
      end
      S_MEMWRITE: begin
        cw_o.mem_req   = 1'b1;
        cw_o.mem_write = 1'b1;
        cw_o.iord      = 1'b1;
      end
      S_RTYPE: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_RT;
        cw_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.regdst    = 1'b1;
        cw_o.memtoreg  = 1'b0;
      end
      S_BRANCH: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_RT;
        cw_o.aluop   = ALUOP_SUB;
        cw_o.pcsrc   = PCSRC_ALUOUT;
        cw_o.branch  = 1'b1;
      end
      S_ADDIEX: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_IMM;
        cw_o.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw_o.reg_write = 1'b1;
        cw_o.regdst    = 1'b0;
        cw_o.memtoreg  = 1'b0;
      end
      S_JUMP: begin
        cw_o.pcsrc    = PCSRC_JUMP;
        cw_o.pc_write = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller for the multi-cycle MIPS core. Moore FSM stepping each
// instruction through fetch/decode/execute/memory/writeback, with a
// req/ready memory handshake and an optional wait timeout.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   Opcode         IR[31:26]; Zero ALU zero flag; MemReady memory done
//   MemReq/MemWrite/IorD              memory request controls
//   IRWrite/PCEn/PCSrc                IR and PC update
//   ALUSrcA/ALUSrcB/ALUOp             ALU operand and operation select
//   RegWrite/RegDst/MemtoReg          register file write controls
//   IllegalOp/MemTimeout              one-cycle event pulses
//   State                             current state for trace
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IllegalOp,
  output logic       MemTimeout,
  output logic [3:0] State
);

  localparam int unsigned WCW = ($clog2(WAIT_LIMIT + 1) < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  ctrl_word_t     cw;
  logic           mem_state;
  logic           timeout;
  logic           illegal;
  logic           ready_ok;

  ctrl_word_decode u_decode (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign mem_state = is_mem_state(state_q);

  // The limit is hit on the cycle the count would reach WAIT_LIMIT; a
  // MemReady on that same cycle completes the access instead.
  assign timeout = (WAIT_LIMIT != 0) && mem_state && !MemReady && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_RTYPE:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // Counting only happens while a memory state is stalled, so any exit
  // (ready, timeout or leaving the state) restarts the count at zero.
  always_comb begin
    wait_d = '0;
    if ((WAIT_LIMIT != 0) && mem_state && !MemReady && !timeout) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Enables raised in a memory state only fire on the completing cycle.
  assign ready_ok = !cw.mem_req || MemReady;

  always_comb begin
    MemReq     = rst_n & cw.mem_req & ~timeout;
    MemWrite   = rst_n & cw.mem_write & ~timeout;
    IRWrite    = rst_n & cw.ir_write & ready_ok;
    PCEn       = rst_n & ((cw.pc_write & ready_ok) | (cw.branch & Zero));
    RegWrite   = rst_n & cw.reg_write & ready_ok;
    IllegalOp  = rst_n & illegal;
    MemTimeout = rst_n & timeout;
    IorD       = cw.iord;
    PCSrc      = cw.pcsrc;
    ALUSrcA    = cw.alusrca;
    ALUSrcB    = cw.alusrcb;
    ALUOp      = cw.aluop;
    RegDst     = cw.regdst;
    MemtoReg   = cw.memtoreg;
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  localparam int unsigned WL = 4;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, RTYPE = 4'd6, ALUWB = 4'd7,
                         BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;

  typedef struct packed {
    logic [3:0] st;
    logic       req, wr, iord, irw, pcen;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb, aluop;
    logic       regw, regdst, m2r, ill, tmo;
  } obs_t;

  typedef struct {
    string      tag;
    logic       rst, ready, zero;
    logic [5:0] op;
    obs_t       exp, mask;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegWrite, RegDst, MemtoReg;
  logic       IllegalOp, MemTimeout;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] State;

  int   vectors = 0;
  int   miscompares = 0;
  step_t q[$];
  obs_t  obs;

  multicycle_ctrl_fsm #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .IllegalOp(IllegalOp), .MemTimeout(MemTimeout), .State(State)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs       = '0;
    obs.st    = State;
    obs.req   = MemReq;
    obs.wr    = MemWrite;
    obs.iord  = IorD;
    obs.irw   = IRWrite;
    obs.pcen  = PCEn;
    obs.pcsrc = PCSrc;
    obs.srca  = ALUSrcA;
    obs.srcb  = ALUSrcB;
    obs.aluop = ALUOp;
    obs.regw  = RegWrite;
    obs.regdst = RegDst;
    obs.m2r   = MemtoReg;
    obs.ill   = IllegalOp;
    obs.tmo   = MemTimeout;
  end

  // Expected outputs of one cycle in state s; stimulus defaults to random.
  function automatic step_t st(input logic [3:0] s, input string tag);
    step_t t;
    t.tag = tag; t.rst = 1'b0;
    t.ready = 1'($urandom); t.zero = 1'($urandom); t.op = 6'($urandom);
    t.exp = '0; t.mask = '0;
    t.exp.st = s;
    t.mask.st = '1; t.mask.req = 1'b1; t.mask.wr = 1'b1; t.mask.irw = 1'b1;
    t.mask.pcen = 1'b1; t.mask.regw = 1'b1; t.mask.ill = 1'b1; t.mask.tmo = 1'b1;
    case (s)
      FETCH: begin
        t.exp.req = 1'b1; t.exp.srcb = 2'b01;
        t.mask.iord = 1'b1; t.mask.srca = 1'b1; t.mask.srcb = '1; t.mask.aluop = '1; t.mask.pcsrc = '1;
      end
      DECODE: begin
        t.exp.srcb = 2'b11; t.mask.srca = 1'b1; t.mask.srcb = '1; t.mask.aluop = '1;
      end
      MEMADR, ADDIEX: begin
        t.exp.srca = 1'b1; t.exp.srcb = 2'b10;
        t.mask.srca = 1'b1; t.mask.srcb = '1; t.mask.aluop = '1;
      end
      MEMREAD: begin
        t.exp.req = 1'b1; t.exp.iord = 1'b1; t.mask.iord = 1'b1;
      end
      MEMWRITE: begin
        t.exp.req = 1'b1; t.exp.wr = 1'b1; t.exp.iord = 1'b1; t.mask.iord = 1'b1;
      end
      MEMWB, ALUWB, ADDIWB: begin
        t.exp.regw = 1'b1;
        t.exp.regdst = (s == ALUWB);
        t.exp.m2r = (s == MEMWB);
        t.mask.regdst = 1'b1; t.mask.m2r = 1'b1;
      end
      RTYPE: begin
        t.exp.srca = 1'b1; t.exp.aluop = 2'b10;
        t.mask.srca = 1'b1; t.mask.srcb = '1; t.mask.aluop = '1;
      end
      BRANCH: begin
        t.exp.srca = 1'b1; t.exp.aluop = 2'b01; t.exp.pcsrc = 2'b01; t.exp.pcen = t.zero;
        t.mask.srca = 1'b1; t.mask.srcb = '1; t.mask.aluop = '1; t.mask.pcsrc = '1;
      end
      JUMP: begin
        t.exp.pcsrc = 2'b10; t.exp.pcen = 1'b1; t.mask.pcsrc = '1;
      end
      default: ;
    endcase
    return t;
  endfunction

  task automatic push_st(input logic [3:0] s, input logic [5:0] op, input string tag);
    step_t t;
    t = st(s, tag);
    t.op = op;
    q.push_back(t);
  endtask

  task automatic push_reset(input string tag);
    step_t t;
    t = st(FETCH, tag);
    t.rst = 1'b1; t.ready = 1'b1; t.exp.req = 1'b0;
    q.push_back(t);
  endtask

  // w stall cycles then completion; w >= WL means the access times out.
  task automatic mem_phase(input logic [3:0] s, input int unsigned w, input logic [5:0] op,
                           input string tag, output bit ok);
    step_t t;
    int unsigned n;
    n = (w >= WL) ? WL - 1 : w;
    for (int unsigned i = 0; i < n; i++) begin
      t = st(s, tag);
      if (s != FETCH) t.op = op;
      t.ready = 1'b0;
      q.push_back(t);
    end
    t = st(s, tag);
    if (s != FETCH) t.op = op;
    if (w >= WL) begin
      t.ready = 1'b0; t.exp.tmo = 1'b1; t.exp.req = 1'b0; t.exp.wr = 1'b0;
      ok = 1'b0;
    end else begin
      t.ready = 1'b1;
      if (s == FETCH) begin t.exp.irw = 1'b1; t.exp.pcen = 1'b1; end
      ok = 1'b1;
    end
    q.push_back(t);
  endtask

  // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 random illegal, 7 opcode 111111
  task automatic gen_instr(input int kind, input int unsigned fw, input int unsigned mw,
                           input int zmode, input string tag);
    step_t t;
    bit ok;
    logic [5:0] op;
    case (kind)
      0: op = 6'b000000;
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      4: op = 6'b001000;
      5: op = 6'b000010;
      7: op = 6'b111111;
      default: begin
        do op = 6'($urandom);
        while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
      end
    endcase
    mem_phase(FETCH, fw, op, tag, ok);
    if (!ok) return;
    t = st(DECODE, tag);
    t.op = op;
    t.exp.ill = (kind >= 6);
    q.push_back(t);
    case (kind)
      0: begin push_st(RTYPE, op, tag); push_st(ALUWB, op, tag); end
      1: begin
        push_st(MEMADR, op, tag);
        mem_phase(MEMREAD, mw, op, tag, ok);
        if (ok) push_st(MEMWB, op, tag);
      end
      2: begin push_st(MEMADR, op, tag); mem_phase(MEMWRITE, mw, op, tag, ok); end
      3: begin
        t = st(BRANCH, tag);
        t.op = op;
        if (zmode != 2) begin t.zero = zmode[0]; t.exp.pcen = zmode[0]; end
        q.push_back(t);
      end
      4: begin push_st(ADDIEX, op, tag); push_st(ADDIWB, op, tag); end
      5: push_st(JUMP, op, tag);
      default: ;
    endcase
  endtask

  initial begin
    push_reset("reset");
    push_reset("reset");
    // reset while the FSM would be in ALUWB: no partial writeback
    gen_instr(0, 0, 0, 2, "rtype_pre_reset");
    void'(q.pop_back());
    push_reset("reset_mid_rtype");
    gen_instr(0, 0, 0, 2, "add");
    gen_instr(1, 0, 3, 2, "lw_wait3");
    gen_instr(3, 0, 0, 1, "beq_taken");
    gen_instr(3, 0, 0, 0, "beq_not_taken");
    gen_instr(7, 0, 0, 2, "illegal_3f");
    gen_instr(0, WL, 0, 2, "fetch_timeout");
    gen_instr(4, WL - 1, 0, 2, "fetch_ready_at_limit");
    gen_instr(1, 1, WL, 2, "memread_timeout");
    gen_instr(2, 2, WL, 2, "memwrite_timeout");
    gen_instr(2, 0, WL - 1, 2, "sw_ready_at_limit");
    gen_instr(5, 0, 0, 2, "jump");
    for (int n = 0; n < 80; n++)
      gen_instr(int'($urandom_range(0, 6)), $urandom_range(0, 5), $urandom_range(0, 5), 2, "random");
    push_reset("reset_final");
    push_st(FETCH, 6'd0, "after_reset");

    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n    = !q[i].rst;
      MemReady = q[i].ready;
      Zero     = q[i].zero;
      Opcode   = q[i].op;
      @(negedge clk);
      vectors++;
      assert ((obs & q[i].mask) === (q[i].exp & q[i].mask))
      else begin
        miscompares++;
        $error("FAIL %s step %0d: observed %h required %h", q[i].tag, i,
               obs & q[i].mask, q[i].exp & q[i].mask);
      end
      if (q[i].rst) begin
        assert ((State === FETCH) && ({MemReq, MemWrite, IRWrite, PCEn, RegWrite,
                                       IllegalOp, MemTimeout} === 7'b0))
        else begin
          miscompares++;
          $error("FAIL reset state %s step %0d: State=%0d enables=%b", q[i].tag, i, State,
                 {MemReq, MemWrite, IRWrite, PCEn, RegWrite, IllegalOp, MemTimeout});
        end
      end
      if (q[i].exp.tmo) begin
        assert ((MemTimeout === 1'b1) && ({MemReq, MemWrite, IRWrite, PCEn, RegWrite} === 5'b0))
        else begin
          miscompares++;
          $error("FAIL expired wait %s step %0d: MemTimeout=%b enables=%b", q[i].tag, i,
                 MemTimeout, {MemReq, MemWrite, IRWrite, PCEn, RegWrite});
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
